cpu_control_unit: RTL and testbench
===================================

# cpu_control_unit

Sequencing controller that drives the 8-bit accumulator's load enable and the datapath selects. Accepts one 8-bit instruction at a time over a valid/ready handshake, walks it through DECODE/EXECUTE/WRITEBACK, and pulses `acc_enable` exactly once per accumulator-writing instruction. Sits between the instruction source and the accumulator/ALU datapath in the CPU core.

## Interface
- No parameters; widths are fixed (8-bit instruction, 8-bit datapath).
- `clock` in 1: single clock, all state updates on its rising edge.
- `reset` in 1: asynchronous, active-low.
- `instr` in 8: `[7:4]` opcode, `[3:0]` operand.
- `instr_valid` in 1: `instr` is valid.
- `instr_ready` out 1: controller can accept an instruction.
- `alu_op` out 3: ALU function select.
- `acc_src_sel` out 1: accumulator input mux; 0 selects the ALU result, 1 selects `imm_data`.
- `imm_data` out 8: `{4'b0, operand}`.
- `acc_enable` out 1: accumulator load enable; one-cycle pulse.
- `out_enable` out 1: output-port load of the accumulator value; one-cycle pulse.
- `illegal` out 1: one-cycle pulse on an undefined opcode.
- `halted` out 1: controller is in HALT.
- `instr_count` out 16: present only with `CTRL_INSTR_COUNT_EN`.

## Operation
- **States:** IDLE, DECODE, EXECUTE, WRITEBACK, HALT. Encoding is free.
- **Opcode map:**
  - 0x0 NOP.
  - 0x1 LOAD: acc ← imm.
  - 0x2 ADD, 0x3 SUB, 0x4 AND, 0x5 OR, 0x6 XOR: acc ← acc op imm. These set `alu_op` = opcode−2, giving 0..4.
  - 0x7 NOT: acc ← ~acc, `alu_op`=5.
  - 0x8 OUT.
  - 0x9 HALT.
  - 0xA–0xF illegal.
- **IDLE:** `instr_ready`=1 while `reset` is high.
  - On `instr_valid && instr_ready` at a clock edge: latch `instr`, go to DECODE.
- **DECODE:**
  - ALU op (0x2–0x7) → EXECUTE.
  - LOAD or OUT → WRITEBACK.
  - NOP → IDLE.
  - HALT → HALT.
  - Illegal → IDLE with `illegal`=1 during this DECODE cycle.
- **EXECUTE:** → WRITEBACK.
- **WRITEBACK:** → IDLE.
  - LOAD or ALU op: `acc_enable`=1. LOAD sets `acc_src_sel`=1; ALU ops set `acc_src_sel`=0.
  - OUT: `out_enable`=1, `acc_enable`=0.
- **HALT:** absorbing state. `halted`=1, `instr_ready`=0. Only `reset` exits it.
- **Moore outputs:**
  - `alu_op` and `acc_src_sel` are driven from DECODE through WRITEBACK and are 0 elsewhere.
  - `imm_data` is driven from DECODE through WRITEBACK and is 0 in IDLE and HALT.
- `instr` and `instr_valid` are ignored outside IDLE. The latched instruction is stable until the next accept.

## Timing
- **Reset:** while `reset`=0, every output is 0 and the state is IDLE, regardless of `clock`. `instr_ready` goes to 1 combinationally when `reset` deasserts.
- **Cycles from the accept edge to returning to IDLE:**

| Instruction | Cycles | Sequence after the accept edge |
|---|---|---|
| ALU op | 4 | DECODE, EXECUTE, WRITEBACK (`acc_enable`), then IDLE |
| LOAD / OUT | 3 | DECODE, WRITEBACK, then IDLE |
| NOP / illegal | 2 | DECODE, then IDLE |

- The accumulator captures on the edge that ends WRITEBACK.
- **No back-to-back accepts:** `instr_ready`=0 from the accept edge until the state returns to IDLE. This gives at most one instruction in flight.
- **Reset mid-operation:** asynchronous abort to IDLE. Any pending `acc_enable` or `out_enable` is suppressed immediately. The latched instruction is discarded.
- **`instr_valid` held high in IDLE:** the next instruction is accepted on the first IDLE edge.

## Configuration
- `CTRL_INSTR_COUNT_EN` defined:
  - Adds the 16-bit `instr_count` output and register.
  - Increments once per retired instruction: on the edge leaving WRITEBACK, or leaving DECODE for NOP.
  - HALT and illegal instructions do not count.
  - Wraps 0xFFFF → 0x0000.
  - Cleared to 0 by `reset`.
- `CTRL_INSTR_COUNT_EN` undefined: no port, no counter. All other behaviour is identical.

## Test plan
- **Reset behaviour:** pulse `reset`=0 mid-ADD while in EXECUTE.
  - Required: all outputs 0 immediately.
  - Required: no `acc_enable` is produced.
  - Required: `instr_ready`=1 after release.
- **LOAD 0x15:**
  - Required: DECODE, then WRITEBACK with `acc_enable`=1, `acc_src_sel`=1, `imm_data`=0x05.
  - Required: `instr_ready`=1 again 3 cycles after the accept edge.
- **ADD 0x23:**
  - Required: in EXECUTE, `alu_op`=0 and `imm_data`=0x03.
  - Required: `acc_enable` high exactly one cycle, in the 3rd cycle after the accept edge.
  - Required: `acc_src_sel`=0.
- **Back-to-back stream 0x11, 0x72, 0x80 with `instr_valid` held high:**
  - Required: accepts spaced 3 and 4 cycles apart.
  - Required: `out_enable` pulses once, with `acc_enable` low in that cycle.
- **Illegal instruction 0xF0:**
  - Required: `illegal` pulses 1 cycle.
  - Required: no enables.
  - Required: back to IDLE after 2 cycles.
  - Required with counter: `instr_count` unchanged.
- **HALT 0x90, then `instr_valid` with 0x11:**
  - Required: `halted`=1, `instr_ready`=0, no accept for 20 cycles.
  - Required: `reset` clears `halted`.
- **Counter wrap (`CTRL_INSTR_COUNT_EN` only):** force `instr_count`=0xFFFF, then retire one NOP.
  - Required: `instr_count`=0x0000.

Source files
------------

// File: rtl/cpu_control_unit_if.sv
// cpu_control_unit_if: instruction handshake plus datapath control bundle
// CTRL_INSTR_COUNT_EN adds the retired-instruction count signal.
interface cpu_control_unit_if;
  logic [7:0] instr;
  logic       instr_valid;
  logic       instr_ready;
  logic [2:0] alu_op;
  logic       acc_src_sel;
  logic [7:0] imm_data;
  logic       acc_enable;
  logic       out_enable;
  logic       illegal;
  logic       halted;
`ifdef CTRL_INSTR_COUNT_EN
  logic [15:0] instr_count;
  modport master (output instr, instr_valid, input instr_ready, alu_op, acc_src_sel, imm_data, acc_enable, out_enable, illegal, halted, instr_count);
  modport slave (input instr, instr_valid, output instr_ready, alu_op, acc_src_sel, imm_data, acc_enable, out_enable, illegal, halted, instr_count);
`else
  modport master (output instr, instr_valid, input instr_ready, alu_op, acc_src_sel, imm_data, acc_enable, out_enable, illegal, halted);
  modport slave (input instr, instr_valid, output instr_ready, alu_op, acc_src_sel, imm_data, acc_enable, out_enable, illegal, halted);
`endif
endinterface

// File: rtl/cpu_control_unit.sv
// cpu_control_unit: sequences one instruction at a time through DECODE/EXECUTE/WRITEBACK
// CTRL_INSTR_COUNT_EN adds a 16-bit retired-instruction counter.
module cpu_control_unit (
  input logic i_clock,
  input logic i_reset,
  cpu_control_unit_if.slave ctrl_if
);
  typedef enum logic [2:0] {S_IDLE, S_DECODE, S_EXECUTE, S_WRITEBACK, S_HALT} state_t;
  state_t     r_state, w_next;
  logic [7:0] r_instr;
  logic [3:0] w_op;
  logic       w_is_alu, w_is_load, w_is_out, w_is_nop, w_is_halt, w_active, w_accept;
  assign w_op      = r_instr[7:4];
  assign w_is_alu  = w_op >= 4'h2 && w_op <= 4'h7;
  assign w_is_load = w_op == 4'h1;
  assign w_is_out  = w_op == 4'h8;
  assign w_is_nop  = w_op == 4'h0;
  assign w_is_halt = w_op == 4'h9;
  assign w_active  = r_state == S_DECODE || r_state == S_EXECUTE || r_state == S_WRITEBACK;
  assign w_accept  = ctrl_if.instr_valid && ctrl_if.instr_ready;
  // State register and instruction latch; reset discards any in-flight instruction
  always_ff @(posedge i_clock or negedge i_reset)
    if (!i_reset) begin
      r_state <= S_IDLE;
      r_instr <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) r_instr <= ctrl_if.instr;
    end
  // Next-state and Moore outputs; ready is gated by reset so it rises only on release
  always_comb begin
    w_next               = r_state;
    ctrl_if.instr_ready  = r_state == S_IDLE && i_reset;
    ctrl_if.alu_op       = w_active && w_is_alu ? r_instr[6:4] - 3'd2 : 3'd0;
    ctrl_if.acc_src_sel  = w_active && w_is_load;
    ctrl_if.imm_data     = w_active ? {4'h0, r_instr[3:0]} : 8'h00;
    ctrl_if.acc_enable   = r_state == S_WRITEBACK && (w_is_load || w_is_alu);
    ctrl_if.out_enable   = r_state == S_WRITEBACK && w_is_out;
    ctrl_if.illegal      = r_state == S_DECODE && w_op >= 4'hA;
    ctrl_if.halted       = r_state == S_HALT;
    case (r_state)
      S_IDLE:      w_next = w_accept ? S_DECODE : S_IDLE;
      S_DECODE:    w_next = w_is_alu ? S_EXECUTE : (w_is_load || w_is_out) ? S_WRITEBACK : w_is_halt ? S_HALT : S_IDLE;
      S_EXECUTE:   w_next = S_WRITEBACK;
      S_WRITEBACK: w_next = S_IDLE;
      default:     w_next = S_HALT;
    endcase
  end
`ifdef CTRL_INSTR_COUNT_EN
  logic [15:0] r_instr_count;
  // Count retirements: leaving WRITEBACK, or leaving DECODE on a NOP
  always_ff @(posedge i_clock or negedge i_reset)
    if (!i_reset) r_instr_count <= '0;
    else if (r_state == S_WRITEBACK || (r_state == S_DECODE && w_is_nop)) r_instr_count <= r_instr_count + 16'd1;
  assign ctrl_if.instr_count = r_instr_count;
`endif
endmodule

// File: tb/tb_cpu_control_unit.sv
// tb_cpu_control_unit: table-driven checks of cpu_control_unit plus multi-cycle corner sequences
module tb_cpu_control_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  cpu_control_unit_if bus();
  cpu_control_unit dut (.i_clock(clk), .i_reset(rst_n), .ctrl_if(bus));
  typedef struct {
    logic [7:0] instr;
    int         cycles;
    int         acc_cyc;
    int         out_cyc;
    bit         ill;
    logic [2:0] alu;
    bit         src;
    int         dcnt;
  } vec_t;
  vec_t vt[11];
  int tests = 0;
  int fails = 0;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  task automatic run_vec(input vec_t v);
    bit done;
    logic [15:0] c0;
    c0 = '0;
    @(negedge clk);
    bus.instr = v.instr;
    bus.instr_valid = 1'b1;
    chk($sformatf("ready_before %h", v.instr), bus.instr_ready, 1);
`ifdef CTRL_INSTR_COUNT_EN
    c0 = bus.instr_count;
`endif
    @(posedge clk);
    #1 bus.instr_valid = 1'b0;
    done = 0;
    for (int k = 1; k <= 20 && !done; k++) begin
      if (bus.instr_ready) begin
        chk($sformatf("cycles %h", v.instr), k, v.cycles);
        chk($sformatf("idle_imm %h", v.instr), bus.imm_data, 0);
        chk($sformatf("idle_alu %h", v.instr), {bus.acc_src_sel, bus.alu_op}, 0);
        done = 1;
      end else begin
        chk($sformatf("acc_en %h k=%0d", v.instr, k), bus.acc_enable, k == v.acc_cyc);
        chk($sformatf("out_en %h k=%0d", v.instr, k), bus.out_enable, k == v.out_cyc);
        chk($sformatf("illegal %h k=%0d", v.instr, k), bus.illegal, v.ill && k == 1);
        chk($sformatf("alu_op %h k=%0d", v.instr, k), bus.alu_op, v.alu);
        chk($sformatf("src_sel %h k=%0d", v.instr, k), bus.acc_src_sel, v.src);
        chk($sformatf("imm %h k=%0d", v.instr, k), bus.imm_data, {4'h0, v.instr[3:0]});
        chk($sformatf("halted %h k=%0d", v.instr, k), bus.halted, 0);
        @(posedge clk);
        #1;
      end
    end
    if (!done) chk($sformatf("timeout %h", v.instr), 0, 1);
`ifdef CTRL_INSTR_COUNT_EN
    chk($sformatf("count_delta %h", v.instr), 16'(bus.instr_count - c0), v.dcnt);
`endif
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    int bad, accs, outs, accp, conf, idx;
    int at[$];
    bit pend;
    logic [7:0] strm[3];
    vt[0]  = '{8'h15, 3, 2, 0, 0, 3'd0, 1, 1};
    vt[1]  = '{8'h23, 4, 3, 0, 0, 3'd0, 0, 1};
    vt[2]  = '{8'h3A, 4, 3, 0, 0, 3'd1, 0, 1};
    vt[3]  = '{8'h4F, 4, 3, 0, 0, 3'd2, 0, 1};
    vt[4]  = '{8'h51, 4, 3, 0, 0, 3'd3, 0, 1};
    vt[5]  = '{8'h66, 4, 3, 0, 0, 3'd4, 0, 1};
    vt[6]  = '{8'h70, 4, 3, 0, 0, 3'd5, 0, 1};
    vt[7]  = '{8'h8C, 3, 0, 2, 0, 3'd0, 0, 1};
    vt[8]  = '{8'h07, 2, 0, 0, 0, 3'd0, 0, 1};
    vt[9]  = '{8'hF0, 2, 0, 0, 1, 3'd0, 0, 0};
    vt[10] = '{8'hA5, 2, 0, 0, 1, 3'd0, 0, 0};
    bus.instr = 8'h23;
    bus.instr_valid = 1'b1;
    #12;
    chk("reset_ready", bus.instr_ready, 0);
    chk("reset_enables", {bus.acc_enable, bus.out_enable, bus.illegal, bus.halted}, 0);
    chk("reset_dp", {bus.acc_src_sel, bus.alu_op, bus.imm_data}, 0);
`ifdef CTRL_INSTR_COUNT_EN
    chk("reset_count", bus.instr_count, 0);
`endif
    @(negedge clk);
    bus.instr_valid = 1'b0;
    rst_n = 1'b1;
    #1 chk("release_ready", bus.instr_ready, 1);
    @(posedge clk);
    #1;
    foreach (vt[i]) run_vec(vt[i]);
    @(negedge clk);
    bus.instr = 8'h23;
    bus.instr_valid = 1'b1;
    @(posedge clk);
    #1 bus.instr_valid = 1'b0;
    @(posedge clk);
    #1 chk("midadd_exec_alu", bus.alu_op, 0);
    chk("midadd_exec_imm", bus.imm_data, 8'h03);
    #2 rst_n = 1'b0;
    #1 chk("midadd_reset_outs", {bus.instr_ready, bus.acc_enable, bus.out_enable, bus.acc_src_sel, bus.alu_op, bus.imm_data}, 0);
    accs = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1 accs += bus.acc_enable;
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("midadd_release_ready", bus.instr_ready, 1);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1 accs += bus.acc_enable;
    end
    chk("midadd_no_acc_enable", accs, 0);
    strm[0] = 8'h11;
    strm[1] = 8'h72;
    strm[2] = 8'h80;
    idx = 0;
    outs = 0;
    accp = 0;
    conf = 0;
    @(negedge clk);
    bus.instr = strm[0];
    bus.instr_valid = 1'b1;
    for (int c = 0; c < 30; c++) begin
      pend = bus.instr_ready && bus.instr_valid;
      if (pend) at.push_back(c);
      @(posedge clk);
      #1;
      if (pend) begin
        idx++;
        if (idx < 3) bus.instr = strm[idx];
        else bus.instr_valid = 1'b0;
      end
      outs += bus.out_enable;
      accp += bus.acc_enable;
      conf += bus.out_enable && bus.acc_enable;
      @(negedge clk);
    end
    chk("stream_accepts", at.size(), 3);
    if (at.size() == 3) begin
      chk("stream_gap1", at[1] - at[0], 3);
      chk("stream_gap2", at[2] - at[1], 4);
    end
    chk("stream_out_pulses", outs, 1);
    chk("stream_acc_pulses", accp, 2);
    chk("stream_out_acc_overlap", conf, 0);
`ifdef CTRL_INSTR_COUNT_EN
    @(negedge clk);
    force dut.r_instr_count = 16'hFFFF;
    #1 release dut.r_instr_count;
    chk("wrap_preset", bus.instr_count, 16'hFFFF);
    run_vec(vt[8]);
    chk("wrap_count", bus.instr_count, 16'h0000);
`endif
    @(negedge clk);
    bus.instr = 8'h90;
    bus.instr_valid = 1'b1;
    @(posedge clk);
    #1 bus.instr = 8'h11;
    @(posedge clk);
    #1 chk("halt_entered", bus.halted, 1);
    bad = 0;
    accs = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      accs += bus.instr_ready && bus.instr_valid;
      bad += !bus.halted || bus.instr_ready || bus.acc_enable || bus.out_enable || (bus.imm_data != 0);
    end
    chk("halt_held", bad, 0);
    chk("halt_no_accept", accs, 0);
    bus.instr_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk("halt_reset_clears", bus.halted, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("halt_release_ready", bus.instr_ready, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
